// File: rtl/pe_loop_sequencer_if.sv
// Control, configuration and pad-address bundle of the PE loop sequencer.
// master: config/instruction-register side, slave: the sequencer itself.
interface pe_loop_sequencer_if #(
  parameter int TW  = 6,
  parameter int PW  = 4,
  parameter int IPA = 6,
  parameter int WPA = 8,
  parameter int PPA = 5
);
  logic           i_start;
  logic           i_abort;
  logic           i_stall;
  logic [TW-1:0]  i_cfg_w;
  logic [PW-1:0]  i_cfg_m;
  logic [PW-1:0]  i_cfg_c;
  logic [PW-1:0]  i_cfg_s;
  logic [2:0]     i_cfg_ab;
  logic           i_cfg_xnor;
  logic           o_busy;
  logic           o_done;
  logic           o_error;
  logic [2:0]     o_err_code;
  logic [1:0]     o_au_mode;
  logic           o_fs_valid;
  logic [IPA-1:0] o_fs_ip_addr;
  logic [WPA-1:0] o_fs_wp_addr;
  logic           o_ms_valid;
  logic           o_ms_psum_init;
  logic           o_ss_valid;
  logic [PPA-1:0] o_ss_pp_addr;
  logic           o_ss_pix_last;

  modport master (
    output i_start, i_abort, i_stall, i_cfg_w, i_cfg_m, i_cfg_c, i_cfg_s,
           i_cfg_ab, i_cfg_xnor,
    input  o_busy, o_done, o_error, o_err_code, o_au_mode, o_fs_valid,
           o_fs_ip_addr, o_fs_wp_addr, o_ms_valid, o_ms_psum_init,
           o_ss_valid, o_ss_pp_addr, o_ss_pix_last
  );

  modport slave (
    input  i_start, i_abort, i_stall, i_cfg_w, i_cfg_m, i_cfg_c, i_cfg_s,
           i_cfg_ab, i_cfg_xnor,
    output o_busy, o_done, o_error, o_err_code, o_au_mode, o_fs_valid,
           o_fs_ip_addr, o_fs_wp_addr, o_ms_valid, o_ms_psum_init,
           o_ss_valid, o_ss_pp_addr, o_ss_pix_last
  );
endinterface

// File: rtl/pe_loop_sequencer.sv
// PE loop sequencer: walks the W -> M -> C -> S loop nest from a latched
// config and issues pad addresses through a 3-stage FS/MS/SS pipeline.
// Addresses are built incrementally (no multipliers): wp is a linear count
// over (m,c,s); ip = base(w*C) + row offset (c) + s*C.
module pe_loop_sequencer #(
  parameter int TW  = 6,
  parameter int PW  = 4,
  parameter int IPA = 6,
  parameter int WPA = 8,
  parameter int PPA = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pe_loop_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_WORK  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [TW-1:0]  cfg_w_q, cfg_w_d, w_q, w_d;
  logic [PW-1:0]  cfg_m_q, cfg_m_d, cfg_c_q, cfg_c_d, cfg_s_q, cfg_s_d;
  logic [PW-1:0]  m_q, m_d, c_q, c_d, s_q, s_d;
  logic [2:0]     cfg_ab_q, cfg_ab_d;
  logic           cfg_xnor_q, cfg_xnor_d;
  logic [IPA-1:0] ip_q, ip_d, row_q, row_d, base_q, base_d;
  logic [WPA-1:0] wp_q, wp_d;
  logic           fs_valid_q, fs_valid_d;
  logic           ms_valid_q, ms_valid_d, ms_init_q, ms_init_d, ms_last_q, ms_last_d;
  logic [PPA-1:0] ms_pp_q, ms_pp_d, ss_pp_q, ss_pp_d;
  logic           ss_valid_q, ss_valid_d, ss_last_q, ss_last_d;
  logic           drain_q, drain_d, done_q, done_d, busy_q, busy_d;
  logic           error_q, error_d;
  logic [2:0]     code_q, code_d, chk_code_s;
  logic [1:0]     au_q, au_d;

  logic           stall_s, last_iter_s;
  logic [TW-1:0]  w_max_s;
  logic [PW-1:0]  m_max_s, c_max_s, s_max_s;
  logic [IPA-1:0] c_ip_s, base_next_s;

  // Config range check in full precision; the first failing rule sets the code.
  function automatic logic [2:0] cfg_check(input logic [TW-1:0] w, input logic [PW-1:0] m,
                                           input logic [PW-1:0] c, input logic [PW-1:0] s,
                                           input logic [2:0] ab, input logic xnor_m);
    logic [31:0] w32, m32, c32, s32;
    logic [2:0]  code;
    w32 = 32'(w);
    m32 = 32'(m);
    c32 = 32'(c);
    s32 = 32'(s);
    if (w32 == 32'd0 || m32 == 32'd0 || c32 == 32'd0 || s32 == 32'd0) code = 3'd1;
    else if ((ab != 3'd1 && ab != 3'd2 && ab != 3'd4) || (xnor_m && ab != 3'd1)) code = 3'd2;
    else if ((w32 + s32 - 32'd1) * c32 > (32'd1 << IPA)) code = 3'd3;
    else if (m32 * c32 * s32 > (32'd1 << WPA)) code = 3'd4;
    else if (m32 > (32'd1 << PPA)) code = 3'd5;
    else code = 3'd0;
    return code;
  endfunction

  assign chk_code_s  = cfg_check(cfg_w_q, cfg_m_q, cfg_c_q, cfg_s_q, cfg_ab_q, cfg_xnor_q);
  assign stall_s     = bus.i_stall && (state_q == ST_WORK || state_q == ST_DRAIN);
  assign w_max_s     = cfg_w_q - TW'(1);
  assign m_max_s     = cfg_m_q - PW'(1);
  assign c_max_s     = cfg_c_q - PW'(1);
  assign s_max_s     = cfg_s_q - PW'(1);
  assign c_ip_s      = IPA'(cfg_c_q);
  assign base_next_s = base_q + c_ip_s;
  assign last_iter_s = (w_q == w_max_s) && (m_q == m_max_s) && (c_q == c_max_s) && (s_q == s_max_s);

  // Next-state, loop-index, address and pipeline computation.
  always_comb begin
    state_d = state_q;   cfg_w_d = cfg_w_q;   cfg_m_d = cfg_m_q;   cfg_c_d = cfg_c_q;
    cfg_s_d = cfg_s_q;   cfg_ab_d = cfg_ab_q; cfg_xnor_d = cfg_xnor_q;
    w_d = w_q; m_d = m_q; c_d = c_q; s_d = s_q;
    ip_d = ip_q; row_d = row_q; base_d = base_q; wp_d = wp_q;
    fs_valid_d = fs_valid_q;
    ms_valid_d = ms_valid_q; ms_init_d = ms_init_q; ms_last_d = ms_last_q; ms_pp_d = ms_pp_q;
    ss_valid_d = ss_valid_q; ss_last_d = ss_last_q; ss_pp_d = ss_pp_q;
    drain_d = drain_q; done_d = 1'b0; error_d = error_q; code_d = code_q; au_d = au_q;

    if (bus.i_abort) begin
      // Abort beats stall and start; error status is left untouched.
      state_d    = ST_IDLE;
      fs_valid_d = 1'b0;
      ms_valid_d = 1'b0;
      ms_init_d  = 1'b0;
      ms_last_d  = 1'b0;
      ss_valid_d = 1'b0;
      ss_last_d  = 1'b0;
    end else begin
      if (!stall_s) begin
        ms_valid_d = fs_valid_q;
        ms_init_d  = fs_valid_q && (c_q == {PW{1'b0}}) && (s_q == {PW{1'b0}});
        ms_last_d  = fs_valid_q && (c_q == c_max_s) && (s_q == s_max_s);
        ms_pp_d    = fs_valid_q ? PPA'(m_q) : {PPA{1'b0}};
        ss_valid_d = ms_valid_q;
        ss_last_d  = ms_last_q;
        ss_pp_d    = ms_pp_q;
      end else begin
        ms_valid_d = ms_valid_q;
        ss_valid_d = ss_valid_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            cfg_w_d = bus.i_cfg_w;   cfg_m_d = bus.i_cfg_m;   cfg_c_d = bus.i_cfg_c;
            cfg_s_d = bus.i_cfg_s;   cfg_ab_d = bus.i_cfg_ab; cfg_xnor_d = bus.i_cfg_xnor;
            error_d = 1'b0;
            code_d  = 3'd0;
            state_d = ST_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_INIT: begin
          if (chk_code_s != 3'd0) begin
            error_d = 1'b1;
            code_d  = chk_code_s;
            state_d = ST_ERR;
          end else begin
            if (cfg_xnor_q) au_d = 2'd3;
            else begin
              case (cfg_ab_q)
                3'd2:    au_d = 2'd1;
                3'd4:    au_d = 2'd2;
                default: au_d = 2'd0;
              endcase
            end
            // First iteration is loaded straight into the FS registers.
            w_d = {TW{1'b0}}; m_d = {PW{1'b0}}; c_d = {PW{1'b0}}; s_d = {PW{1'b0}};
            ip_d = {IPA{1'b0}}; row_d = {IPA{1'b0}}; base_d = {IPA{1'b0}}; wp_d = {WPA{1'b0}};
            fs_valid_d = 1'b1;
            state_d    = ST_WORK;
          end
        end
        ST_WORK: begin
          if (stall_s) begin
            state_d = ST_WORK;
          end else if (last_iter_s) begin
            fs_valid_d = 1'b0;
            drain_d    = 1'b0;
            state_d    = ST_DRAIN;
          end else begin
            wp_d = wp_q + WPA'(1);
            if (s_q != s_max_s) begin
              s_d  = s_q + PW'(1);
              ip_d = ip_q + c_ip_s;
            end else begin
              s_d = {PW{1'b0}};
              if (c_q != c_max_s) begin
                c_d   = c_q + PW'(1);
                row_d = row_q + IPA'(1);
                ip_d  = row_q + IPA'(1);
              end else begin
                c_d = {PW{1'b0}};
                if (m_q != m_max_s) begin
                  m_d   = m_q + PW'(1);
                  row_d = base_q;
                  ip_d  = base_q;
                end else begin
                  m_d    = {PW{1'b0}};
                  w_d    = w_q + TW'(1);
                  base_d = base_next_s;
                  row_d  = base_next_s;
                  ip_d   = base_next_s;
                  wp_d   = {WPA{1'b0}};
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (stall_s) begin
            state_d = ST_DRAIN;
          end else if (drain_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            drain_d = 1'b1;
          end
        end
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Config, loop indices, address registers, pipeline and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_w_q <= '0; cfg_m_q <= '0; cfg_c_q <= '0; cfg_s_q <= '0;
      cfg_ab_q <= 3'd0; cfg_xnor_q <= 1'b0;
      w_q <= '0; m_q <= '0; c_q <= '0; s_q <= '0;
      ip_q <= '0; row_q <= '0; base_q <= '0; wp_q <= '0;
      fs_valid_q <= 1'b0;
      ms_valid_q <= 1'b0; ms_init_q <= 1'b0; ms_last_q <= 1'b0; ms_pp_q <= '0;
      ss_valid_q <= 1'b0; ss_last_q <= 1'b0; ss_pp_q <= '0;
      drain_q <= 1'b0; done_q <= 1'b0; busy_q <= 1'b0;
      error_q <= 1'b0; code_q <= 3'd0; au_q <= 2'd0;
    end else begin
      cfg_w_q <= cfg_w_d; cfg_m_q <= cfg_m_d; cfg_c_q <= cfg_c_d; cfg_s_q <= cfg_s_d;
      cfg_ab_q <= cfg_ab_d; cfg_xnor_q <= cfg_xnor_d;
      w_q <= w_d; m_q <= m_d; c_q <= c_d; s_q <= s_d;
      ip_q <= ip_d; row_q <= row_d; base_q <= base_d; wp_q <= wp_d;
      fs_valid_q <= fs_valid_d;
      ms_valid_q <= ms_valid_d; ms_init_q <= ms_init_d; ms_last_q <= ms_last_d; ms_pp_q <= ms_pp_d;
      ss_valid_q <= ss_valid_d; ss_last_q <= ss_last_d; ss_pp_q <= ss_pp_d;
      drain_q <= drain_d; done_q <= done_d; busy_q <= busy_d;
      error_q <= error_d; code_q <= code_d; au_q <= au_d;
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_error        = error_q;
  assign bus.o_err_code     = code_q;
  assign bus.o_au_mode      = au_q;
  assign bus.o_fs_valid     = fs_valid_q;
  assign bus.o_fs_ip_addr   = ip_q;
  assign bus.o_fs_wp_addr   = wp_q;
  assign bus.o_ms_valid     = ms_valid_q;
  assign bus.o_ms_psum_init = ms_init_q;
  assign bus.o_ss_valid     = ss_valid_q;
  assign bus.o_ss_pp_addr   = ss_pp_q;
  assign bus.o_ss_pix_last  = ss_last_q;

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Directed bench for pe_loop_sequencer: loop-nest address sequences, pipeline
// flags, stall, abort, config errors and reset, against hand-computed values.
module tb_pe_loop_sequencer;
  localparam int TW = 6, PW = 4, IPA = 6, WPA = 8, PPA = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pe_loop_sequencer_if #(.TW(TW), .PW(PW), .IPA(IPA), .WPA(WPA), .PPA(PPA)) bus ();

  pe_loop_sequencer #(.TW(TW), .PW(PW), .IPA(IPA), .WPA(WPA), .PPA(PPA)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int ip_l[$], wp_l[$], init_l[$], pp_l[$], last_l[$];
  int done_cyc, done_cnt;
  int p_busy, p_fs_valid, p_fs_ip, p_fs_wp, p_ms_valid, p_ms_init, p_ss_valid;

  task automatic chk_eq(input string tag, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, want);
    end
  endtask

  task automatic chk_seq(input string tag, input int got[$], input int want[$]);
    chk_eq({tag, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk_eq($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, want[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int w, input int m, input int c, input int s,
                         input int ab, input int xn);
    bus.i_cfg_w    = TW'(w);
    bus.i_cfg_m    = PW'(m);
    bus.i_cfg_c    = PW'(c);
    bus.i_cfg_s    = PW'(s);
    bus.i_cfg_ab   = 3'(ab);
    bus.i_cfg_xnor = (xn != 0);
  endtask

  // Start pulse, then max_cyc cycles; beats recorded only after unstalled edges.
  task automatic run(input int stall_at, input int stall_len, input int abort_at,
                     input int probe_cyc, input int max_cyc);
    int st;
    ip_l.delete(); wp_l.delete(); init_l.delete(); pp_l.delete(); last_l.delete();
    done_cyc = -1;
    done_cnt = 0;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      st = (cyc > stall_at && cyc <= stall_at + stall_len) ? 1 : 0;
      bus.i_stall = (st == 1);
      bus.i_abort = (cyc == abort_at);
      step();
      if (bus.o_fs_valid && st == 0) begin
        ip_l.push_back(int'(bus.o_fs_ip_addr));
        wp_l.push_back(int'(bus.o_fs_wp_addr));
      end
      if (bus.o_ms_valid && st == 0) init_l.push_back(int'(bus.o_ms_psum_init));
      if (bus.o_ss_valid && st == 0) begin
        pp_l.push_back(int'(bus.o_ss_pp_addr));
        last_l.push_back(int'(bus.o_ss_pix_last));
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == probe_cyc) begin
        p_busy     = int'(bus.o_busy);
        p_fs_valid = int'(bus.o_fs_valid);
        p_fs_ip    = int'(bus.o_fs_ip_addr);
        p_fs_wp    = int'(bus.o_fs_wp_addr);
        p_ms_valid = int'(bus.o_ms_valid);
        p_ms_init  = int'(bus.o_ms_psum_init);
        p_ss_valid = int'(bus.o_ss_valid);
      end
    end
    bus.i_stall = 1'b0;
    bus.i_abort = 1'b0;
  endtask

  // Start with an illegal config: INIT, then ERR with the code, then IDLE.
  task automatic err_case(input string tag, input int want_code);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk_eq({tag, "_err_cleared"}, int'(bus.o_error), 0);
    step();
    chk_eq({tag, "_err_set"}, int'(bus.o_error), 1);
    chk_eq({tag, "_code"}, int'(bus.o_err_code), want_code);
    chk_eq({tag, "_fs_valid"}, int'(bus.o_fs_valid), 0);
    step();
    chk_eq({tag, "_busy_after"}, int'(bus.o_busy), 0);
    chk_eq({tag, "_err_hold"}, int'(bus.o_error), 1);
    chk_eq({tag, "_code_hold"}, int'(bus.o_err_code), want_code);
    chk_eq({tag, "_ss_valid"}, int'(bus.o_ss_valid), 0);
  endtask

  initial begin
    int e_ip[$], e_wp[$], e_init[$], e_pp[$], e_last[$];
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_stall = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    // Reset values.
    step();
    step();
    chk_eq("rst_busy", int'(bus.o_busy), 0);
    chk_eq("rst_fs_valid", int'(bus.o_fs_valid), 0);
    chk_eq("rst_done", int'(bus.o_done), 0);
    chk_eq("rst_error", int'(bus.o_error), 0);
    chk_eq("rst_code", int'(bus.o_err_code), 0);
    chk_eq("rst_au", int'(bus.o_au_mode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // W=2 M=1 C=1 S=3 ab=1.
    set_cfg(2, 1, 1, 3, 1, 0);
    run(0, 0, 0, 0, 14);
    e_ip = '{0, 1, 2, 1, 2, 3};     chk_seq("s1_ip", ip_l, e_ip);
    e_wp = '{0, 1, 2, 0, 1, 2};     chk_seq("s1_wp", wp_l, e_wp);
    e_init = '{1, 0, 0, 1, 0, 0};   chk_seq("s1_init", init_l, e_init);
    e_last = '{0, 0, 1, 0, 0, 1};   chk_seq("s1_last", last_l, e_last);
    e_pp = '{0, 0, 0, 0, 0, 0};     chk_seq("s1_pp", pp_l, e_pp);
    chk_eq("s1_done_cyc", done_cyc, 9);
    chk_eq("s1_done_cnt", done_cnt, 1);
    chk_eq("s1_au", int'(bus.o_au_mode), 0);
    chk_eq("s1_busy_end", int'(bus.o_busy), 0);

    // W=1 M=2 C=2 S=1 ab=4.
    set_cfg(1, 2, 2, 1, 4, 0);
    run(0, 0, 0, 0, 12);
    e_ip = '{0, 1, 0, 1};           chk_seq("s2_ip", ip_l, e_ip);
    e_wp = '{0, 1, 2, 3};           chk_seq("s2_wp", wp_l, e_wp);
    e_pp = '{0, 0, 1, 1};           chk_seq("s2_pp", pp_l, e_pp);
    e_last = '{0, 1, 0, 1};         chk_seq("s2_last", last_l, e_last);
    e_init = '{1, 0, 1, 0};         chk_seq("s2_init", init_l, e_init);
    chk_eq("s2_au", int'(bus.o_au_mode), 2);
    chk_eq("s2_done_cyc", done_cyc, 7);

    // Scenario 1 with a 3-cycle stall after the 2nd FS beat.
    set_cfg(2, 1, 1, 3, 1, 0);
    run(2, 3, 0, 5, 18);
    e_ip = '{0, 1, 2, 1, 2, 3};     chk_seq("st_ip", ip_l, e_ip);
    e_wp = '{0, 1, 2, 0, 1, 2};     chk_seq("st_wp", wp_l, e_wp);
    e_last = '{0, 0, 1, 0, 0, 1};   chk_seq("st_last", last_l, e_last);
    chk_eq("st_done_cyc", done_cyc, 12);
    chk_eq("st_done_cnt", done_cnt, 1);
    chk_eq("st_frz_fs_valid", p_fs_valid, 1);
    chk_eq("st_frz_fs_ip", p_fs_ip, 1);
    chk_eq("st_frz_fs_wp", p_fs_wp, 1);
    chk_eq("st_frz_ms_valid", p_ms_valid, 1);
    chk_eq("st_frz_ms_init", p_ms_init, 1);
    chk_eq("st_frz_ss_valid", p_ss_valid, 0);

    // Single-iteration xnor run.
    set_cfg(1, 1, 1, 1, 1, 1);
    run(0, 0, 0, 0, 8);
    chk_eq("xn_au", int'(bus.o_au_mode), 3);
    chk_eq("xn_done_cyc", done_cyc, 4);
    e_last = '{1};                  chk_seq("xn_last", last_l, e_last);

    // Config errors.
    set_cfg(2, 1, 1, 3, 3, 0);   err_case("e_ab3", 2);
    set_cfg(2, 1, 0, 3, 1, 0);   err_case("e_c0", 1);
    set_cfg(1, 1, 1, 1, 2, 1);   err_case("e_xnor_ab2", 2);
    set_cfg(60, 1, 2, 1, 1, 0);  err_case("e_ip_range", 3);
    set_cfg(1, 5, 15, 4, 1, 0);  err_case("e_wp_range", 4);

    // Error stays set while idle; start+abort in IDLE keeps IDLE and error.
    step();
    step();
    chk_eq("sticky_err", int'(bus.o_error), 1);
    set_cfg(2, 1, 1, 3, 1, 0);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk_eq("sa_busy", int'(bus.o_busy), 0);
    chk_eq("sa_err", int'(bus.o_error), 1);
    step();
    chk_eq("sa_busy2", int'(bus.o_busy), 0);

    // Abort during the 4th WORK cycle, then a clean full run.
    run(0, 0, 5, 5, 14);
    chk_eq("ab_busy", p_busy, 0);
    chk_eq("ab_fs_valid", p_fs_valid, 0);
    chk_eq("ab_ms_valid", p_ms_valid, 0);
    chk_eq("ab_ss_valid", p_ss_valid, 0);
    chk_eq("ab_done_cnt", done_cnt, 0);
    chk_eq("ab_fs_beats", ip_l.size(), 4);
    chk_eq("ab_err_cleared", int'(bus.o_error), 0);
    chk_eq("ab_code_cleared", int'(bus.o_err_code), 0);
    run(0, 0, 0, 0, 14);
    e_ip = '{0, 1, 2, 1, 2, 3};     chk_seq("ab2_ip", ip_l, e_ip);
    chk_eq("ab2_done_cyc", done_cyc, 9);

    // Asynchronous reset in the middle of WORK.
    set_cfg(2, 1, 1, 3, 1, 0);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    step();
    step();
    step();
    chk_eq("mr_pre_ip", int'(bus.o_fs_ip_addr), 2);
    rst_n = 1'b0;
    #1;
    chk_eq("mr_busy", int'(bus.o_busy), 0);
    chk_eq("mr_fs_valid", int'(bus.o_fs_valid), 0);
    chk_eq("mr_fs_ip", int'(bus.o_fs_ip_addr), 0);
    chk_eq("mr_ms_valid", int'(bus.o_ms_valid), 0);
    chk_eq("mr_ss_valid", int'(bus.o_ss_valid), 0);
    chk_eq("mr_au", int'(bus.o_au_mode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_eq("mr_busy_after", int'(bus.o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
